// File: rtl/cpu_decode_if.sv
// Decode-stage bus: fetch handshake, register-file read port, flush
// from commit, and the decoded output register toward execute.
// The decode stage sits on the slave side; fetch/regfile/execute
// collectively form the master side.
interface cpu_decode_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            fetch_valid;
   logic [31:0]     fetch_instr;
   logic [XLEN-1:0] fetch_pc;
   logic            fetch_ready;

   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;

   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_pc;
   logic [2:0]      ex_alu_op;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_rs1_val;
   logic [XLEN-1:0] ex_rs2_val;
   logic [XLEN-1:0] ex_imm;
   logic [5:0]      ex_ctrl;
   logic            ex_illegal;

   modport master (
      output flush, fetch_valid, fetch_instr, fetch_pc,
      output rs1_data, rs2_data, ex_ready,
      input  fetch_ready, rs1_addr, rs2_addr,
      input  ex_valid, ex_pc, ex_alu_op, ex_rd, ex_rs1_val, ex_rs2_val,
      input  ex_imm, ex_ctrl, ex_illegal
   );

   modport slave (
      input  flush, fetch_valid, fetch_instr, fetch_pc,
      input  rs1_data, rs2_data, ex_ready,
      output fetch_ready, rs1_addr, rs2_addr,
      output ex_valid, ex_pc, ex_alu_op, ex_rd, ex_rs1_val, ex_rs2_val,
      output ex_imm, ex_ctrl, ex_illegal
   );
endinterface

// File: rtl/cpu_decode.sv
// Decode stage: field split, register operand capture, control
// generation, load-use bubble insertion and commit-side flush.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_EMPTY | output register holds no instruction (ex_valid=0)
// ST_FULL  | output register holds a decoded instruction
module cpu_decode #(
   parameter int XLEN = 32,
   parameter int REGS = 32
) (
   input logic         clock,
   input logic         reset,
   cpu_decode_if.slave bus
);
   localparam int RA_W = $clog2(REGS);

   typedef enum logic [2:0] {
      ALU_ADD    = 3'd0,
      ALU_SUB    = 3'd1,
      ALU_MUL    = 3'd2,
      ALU_PASS_B = 3'd3
   } alu_op_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [6:0] OP_ADD  = 7'h00;
   localparam logic [6:0] OP_SUB  = 7'h01;
   localparam logic [6:0] OP_MUL  = 7'h02;
   localparam logic [6:0] OP_LDB  = 7'h10;
   localparam logic [6:0] OP_LDW  = 7'h11;
   localparam logic [6:0] OP_STB  = 7'h12;
   localparam logic [6:0] OP_STW  = 7'h13;
   localparam logic [6:0] OP_BEQ  = 7'h30;
   localparam logic [6:0] OP_JUMP = 7'h31;
   localparam logic [6:0] OP_NOP  = 7'h7F;

   // control vector layout: {reg_write, mem_read, mem_write, mem_byte, branch, jump}
   localparam logic [5:0] C_REG_WRITE = 6'b100000;
   localparam logic [5:0] C_MEM_READ  = 6'b010000;
   localparam logic [5:0] C_MEM_WRITE = 6'b001000;
   localparam logic [5:0] C_MEM_BYTE  = 6'b000100;
   localparam logic [5:0] C_BRANCH    = 6'b000010;
   localparam logic [5:0] C_JUMP      = 6'b000001;
   localparam int         MR_BIT      = 4;

   // instruction fields
   logic [6:0]      opcode;
   logic [RA_W-1:0] f_rd;
   logic [RA_W-1:0] f_rs1;
   logic [RA_W-1:0] f_rs2;
   logic [14:0]     imm15;

   // decode results for the word currently at fetch
   alu_op_t         dec_alu;
   logic [5:0]      dec_ctrl;
   logic            dec_illegal;
   logic            dec_uses_rs2;
   logic [XLEN-1:0] dec_rs1_val;
   logic [XLEN-1:0] dec_rs2_val;
   logic [XLEN-1:0] dec_imm;

   // pipeline control
   state_t          state_q;
   state_t          state_d;
   logic            load;
   logic            advance;
   logic            hazard;
   logic            ready_int;

   // output register
   logic [XLEN-1:0] ex_pc_q;
   alu_op_t         ex_alu_q;
   logic [RA_W-1:0] ex_rd_q;
   logic [XLEN-1:0] ex_rs1_q;
   logic [XLEN-1:0] ex_rs2_q;
   logic [XLEN-1:0] ex_imm_q;
   logic [5:0]      ex_ctrl_q;
   logic            ex_ill_q;

   assign opcode = bus.fetch_instr[31:25];
   assign f_rd   = bus.fetch_instr[24:20];
   assign f_rs1  = bus.fetch_instr[19:15];
   assign f_rs2  = bus.fetch_instr[14:10];
   assign imm15  = bus.fetch_instr[14:0];

   // register-file read addresses come straight from the fetch word so
   // the read data returns within the same cycle
   assign bus.rs1_addr = f_rs1;
   assign bus.rs2_addr = f_rs2;

   // r0 is hardwired to zero whatever the register file returns
   assign dec_rs1_val = (f_rs1 == '0) ? '0 : bus.rs1_data;
   assign dec_rs2_val = (f_rs2 == '0) ? '0 : bus.rs2_data;
   assign dec_imm     = {{(XLEN-15){imm15[14]}}, imm15};

   // opcode to ALU operation, control vector and rs2-dependency
   always_comb begin
      dec_alu      = ALU_ADD;
      dec_ctrl     = '0;
      dec_illegal  = 1'b0;
      dec_uses_rs2 = 1'b0;
      case (opcode)
         OP_ADD: begin
            dec_ctrl     = C_REG_WRITE;
            dec_uses_rs2 = 1'b1;
         end
         OP_SUB: begin
            dec_alu      = ALU_SUB;
            dec_ctrl     = C_REG_WRITE;
            dec_uses_rs2 = 1'b1;
         end
         OP_MUL: begin
            dec_alu      = ALU_MUL;
            dec_ctrl     = C_REG_WRITE;
            dec_uses_rs2 = 1'b1;
         end
         OP_LDB: dec_ctrl = C_REG_WRITE | C_MEM_READ | C_MEM_BYTE;
         OP_LDW: dec_ctrl = C_REG_WRITE | C_MEM_READ;
         OP_STB: begin
            dec_ctrl     = C_MEM_WRITE | C_MEM_BYTE;
            dec_uses_rs2 = 1'b1;
         end
         OP_STW: begin
            dec_ctrl     = C_MEM_WRITE;
            dec_uses_rs2 = 1'b1;
         end
         OP_BEQ: begin
            dec_alu      = ALU_SUB;
            dec_ctrl     = C_BRANCH;
            dec_uses_rs2 = 1'b1;
         end
         OP_JUMP: begin
            dec_alu  = ALU_PASS_B;
            dec_ctrl = C_JUMP;
         end
         OP_NOP: dec_ctrl = '0;
         default: dec_illegal = 1'b1;
      endcase
   end

   // A load still in the output register cannot forward its result, so a
   // consumer at fetch must wait one cycle. Loads to r0 never conflict, and
   // immediate-form opcodes reuse the rs2 bits as immediate, so only true
   // rs2 readers compare against them.
   assign hazard = (state_q == ST_FULL) && ex_ctrl_q[MR_BIT] && (ex_rd_q != '0) &&
                   ((ex_rd_q == f_rs1) || (dec_uses_rs2 && (ex_rd_q == f_rs2)));

   assign advance         = (state_q == ST_EMPTY) || bus.ex_ready;
   assign ready_int       = advance && !hazard && !bus.flush;
   assign bus.fetch_ready = ready_int;

   // next occupancy of the output register; flush outranks everything
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end else if (advance) begin
         if (bus.fetch_valid && ready_int) begin
            state_d = ST_FULL;
            load    = 1'b1;
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   // occupancy state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // decoded payload; holds on stall, bubble and flush
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_pc_q   <= '0;
         ex_alu_q  <= ALU_ADD;
         ex_rd_q   <= '0;
         ex_rs1_q  <= '0;
         ex_rs2_q  <= '0;
         ex_imm_q  <= '0;
         ex_ctrl_q <= '0;
         ex_ill_q  <= 1'b0;
      end else if (load) begin
         ex_pc_q   <= bus.fetch_pc;
         ex_alu_q  <= dec_alu;
         ex_rd_q   <= f_rd;
         ex_rs1_q  <= dec_rs1_val;
         ex_rs2_q  <= dec_rs2_val;
         ex_imm_q  <= dec_imm;
         ex_ctrl_q <= dec_ctrl;
         ex_ill_q  <= dec_illegal;
      end
   end

   assign bus.ex_valid   = (state_q == ST_FULL);
   assign bus.ex_pc      = ex_pc_q;
   assign bus.ex_alu_op  = ex_alu_q;
   assign bus.ex_rd      = ex_rd_q;
   assign bus.ex_rs1_val = ex_rs1_q;
   assign bus.ex_rs2_val = ex_rs2_q;
   assign bus.ex_imm     = ex_imm_q;
   assign bus.ex_ctrl    = ex_ctrl_q;
   assign bus.ex_illegal = ex_ill_q;
endmodule
